idu_ir_rename: RTL and testbench
================================

// Module: idu_ir_rename
// PURPOSE
//  Single-issue rename stage between the instruction decoder and the ROB / PST preg table.
//  - Consumes decoded instructions, the allocated iid, and the allocated preg.
//  - Maps src1/src2/dst through a 32-entry speculative rename table.
//  - Drives the ROB create and PST create requests.
//  - Restores the table from the PST recover table on global flush.
// PARAMETERS
//  GPR_NUM   32  architectural GPR count (index width 5)
//  PREG_W    6   physical register index width (64 pregs)
//  IID_W     4   ROB instruction id width
// PORTS
//  clk                              in   1    core clock, rising edge
//  rst_clk                          in   1    asynchronous active-low reset
//  rtu_global_flush                 in   1    flush; highest priority
//  rtu_idu_ir_recover_table         in   192  committed map; entry i = bits [6i+5:6i]
//  y_idu_ir_stall_ctrl              in   1    downstream (ROB/issue) back-pressure
//  idu_idu_ir_vld                   in   1    decoded instruction valid
//  idu_idu_ir_pc                    in   64   instruction pc
//  idu_idu_ir_src1_vld/src1         in   1/5  source 1
//  idu_idu_ir_src2_vld/src2         in   1/5  source 2
//  idu_idu_ir_dst_vld/dst           in   1/5  destination
//  idu_idu_ir_opcode/funct3/imm_vld/imm/type/pipe/ras  in  7/3/1/64/6/5/1  passthrough
//  rtu_idu_is_iid_vld/iid           in   1/4  iid available from ROB
//  rtu_idu_is_preg_vld/preg         in   1/6  free preg available from PST
//  idu_ir_stall                     out  1    upstream must hold decode outputs
//  idu_rtu_rob_create_vld           out  1    ROB create; consumes offered iid
//  idu_rtu_rob_create_*             out  -    pc/src1/src1_vld/psrc1/src2/src2_vld/psrc2/dst/dst_vld/pdst + passthrough
//  idu_rtu_pst_create_vld           out  1    PST create; consumes offered preg
//  idu_rtu_pst_create_preg_index    out  6    new preg for dst
//  idu_rtu_pst_create_iid           out  4    owning iid
//  idu_rtu_pst_create_gpr_index     out  5    architectural dst
//  idu_rtu_pst_create_gpr_pre_preg_index out 6  previous mapping of dst (freed at retire)
// BEHAVIOUR
//  Reset:
//  - RT[i]=i for all i.
//  - All *_vld outputs are 0; all data outputs are 0; idu_ir_stall=0.
//  Per-instruction resources:
//  - Every instruction needs an iid.
//  - need_preg = dst_vld && dst!=0. dst==0 is treated as dst_vld=0: no preg and no PST create.
//  Stall and accept:
//  - hold   = out_vld && y_idu_ir_stall_ctrl
//  - lack   = !iid_vld || (need_preg && !preg_vld)
//  - idu_ir_stall = idu_idu_ir_vld && (hold || lack) && !flush  (combinational)
//  - accept = idu_idu_ir_vld && !idu_ir_stall && !flush
//  Latency 1:
//  - On accept, output registers load at the next edge:
//    * psrcN = (srcN==0) ? 0 : RT[srcN]
//    * pdst  = preg
//    * iid captured
//  - rob_create_vld=1 on accept; pst_create_vld=need_preg.
//  - If there is no accept and no hold, the output valids clear. When hold=1, all outputs hold their values.
//  Rename update:
//  - On accept with need_preg, RT[dst] <= preg and gpr_pre_preg_index = old RT[dst], at the same edge.
//  - The next instruction reads the updated RT, so back-to-back RAW chains need no bypass.
//  - The lookup always reads RT before the current write, so src==dst in one instruction sees the old mapping.
//  Flush (highest priority):
//  - RT <= recover_table, output valids <= 0, the input is dropped, and no iid/preg is consumed.
//  - Flush coinciding with accept or hold: flush wins.
//  Reset asserted mid-operation:
//  - Immediate async clear to the reset state; any pending create is lost.
//  Other rules:
//  - RT[0] is never written; it stays 0 after reset and after flush (recover entry 0 is ignored and forced to 0).
//  - The allocators must keep iid/preg stable while offered; consumption is only via the create_vld pulses.
// STRUCTURE
//  - const.v gains IDU_GPR_NUM, IDU_PREG_W, IDU_IID_W and the recover-table width (GPR_NUM*PREG_W).
//  - Sub-module idu_ir_rt: 32x6 flop table, 3 combinational read ports, 1 write port, and bulk load from the recover bus.
//  - The top holds the stall logic and the output pipeline register.
// TESTING
//  1. Reset release, then add x5,x1,x2 with iid=3, preg=40:
//     -> next cycle rob_create_vld=1, psrc1=1, psrc2=2, pdst=40;
//     -> pst_create_vld=1, gpr=5, pre=5, iid=3.
//  2. Back-to-back: x5<-preg40, then x6=x5+x5 with preg41:
//     -> psrc1=psrc2=40, pre_preg=6.
//  3. Dst x0 with preg_vld=0:
//     -> accepted; rob_create_vld=1, pst_create_vld=0; RT unchanged.
//  4. need_preg with preg_vld=0 for 3 cycles:
//     -> idu_ir_stall=1 for 3 cycles, no creates; accepted on the cycle preg_vld rises.
//  5. out_vld with y_idu_ir_stall_ctrl=1 for 2 cycles:
//     -> outputs held, idu_ir_stall=1, RT unchanged.
//  6. Rename x5->40, then flush with a recover table mapping x5->5 while a new instruction is valid:
//     -> valids 0, no create; the next x7=x5 gives psrc1=5.

Source files
------------

// File: rtl/idu_ir_rename_pkg.sv
// Shared widths, types and helpers for the IDU rename stage.
// Imported by the rename table, the top and the bus interface.
package idu_ir_rename_pkg;

  localparam int GPR_NUM = 32;
  localparam int GPR_W   = 5;
  localparam int PREG_W  = 6;
  localparam int IID_W   = 4;
  localparam int RT_W    = GPR_NUM * PREG_W;

  typedef logic [GPR_W-1:0]  gpr_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [IID_W-1:0]  iid_t;

  // Registered payload of one renamed instruction.
  typedef struct packed {
    logic [63:0] pc;
    logic        src1_vld;
    gpr_t        src1;
    preg_t       psrc1;
    logic        src2_vld;
    gpr_t        src2;
    preg_t       psrc2;
    logic        dst_vld;
    gpr_t        dst;
    preg_t       pdst;
    preg_t       pre_preg;
    iid_t        iid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        imm_vld;
    logic [63:0] imm;
    logic [5:0]  itype;
    logic [4:0]  pipe;
    logic        ras;
  } ir_out_t;

  // x0 is hard-wired, so writing it never needs a physical register.
  function automatic logic need_preg(input logic dst_vld, input gpr_t dst);
    return dst_vld && (dst != '0);
  endfunction

endpackage

// File: rtl/idu_ir_rename_if.sv
// Decode-in / ROB+PST-create-out bundle of the rename stage.
// slave is the rename block; master is its environment.
interface idu_ir_rename_if;
  import idu_ir_rename_pkg::*;

  logic              rtu_global_flush;
  logic [RT_W-1:0]   rtu_idu_ir_recover_table;
  logic              y_idu_ir_stall_ctrl;

  logic              idu_idu_ir_vld;
  logic [63:0]       idu_idu_ir_pc;
  logic              idu_idu_ir_src1_vld;
  gpr_t              idu_idu_ir_src1;
  logic              idu_idu_ir_src2_vld;
  gpr_t              idu_idu_ir_src2;
  logic              idu_idu_ir_dst_vld;
  gpr_t              idu_idu_ir_dst;
  logic [6:0]        idu_idu_ir_opcode;
  logic [2:0]        idu_idu_ir_funct3;
  logic              idu_idu_ir_imm_vld;
  logic [63:0]       idu_idu_ir_imm;
  logic [5:0]        idu_idu_ir_type;
  logic [4:0]        idu_idu_ir_pipe;
  logic              idu_idu_ir_ras;

  logic              rtu_idu_is_iid_vld;
  iid_t              rtu_idu_is_iid;
  logic              rtu_idu_is_preg_vld;
  preg_t             rtu_idu_is_preg;

  logic              idu_ir_stall;

  logic              idu_rtu_rob_create_vld;
  logic [63:0]       idu_rtu_rob_create_pc;
  gpr_t              idu_rtu_rob_create_src1;
  logic              idu_rtu_rob_create_src1_vld;
  preg_t             idu_rtu_rob_create_psrc1;
  gpr_t              idu_rtu_rob_create_src2;
  logic              idu_rtu_rob_create_src2_vld;
  preg_t             idu_rtu_rob_create_psrc2;
  gpr_t              idu_rtu_rob_create_dst;
  logic              idu_rtu_rob_create_dst_vld;
  preg_t             idu_rtu_rob_create_pdst;
  iid_t              idu_rtu_rob_create_iid;
  logic [6:0]        idu_rtu_rob_create_opcode;
  logic [2:0]        idu_rtu_rob_create_funct3;
  logic              idu_rtu_rob_create_imm_vld;
  logic [63:0]       idu_rtu_rob_create_imm;
  logic [5:0]        idu_rtu_rob_create_type;
  logic [4:0]        idu_rtu_rob_create_pipe;
  logic              idu_rtu_rob_create_ras;

  logic              idu_rtu_pst_create_vld;
  preg_t             idu_rtu_pst_create_preg_index;
  iid_t              idu_rtu_pst_create_iid;
  gpr_t              idu_rtu_pst_create_gpr_index;
  preg_t             idu_rtu_pst_create_gpr_pre_preg_index;

  modport slave (
    input  rtu_global_flush, rtu_idu_ir_recover_table, y_idu_ir_stall_ctrl,
    input  idu_idu_ir_vld, idu_idu_ir_pc,
    input  idu_idu_ir_src1_vld, idu_idu_ir_src1, idu_idu_ir_src2_vld, idu_idu_ir_src2,
    input  idu_idu_ir_dst_vld, idu_idu_ir_dst,
    input  idu_idu_ir_opcode, idu_idu_ir_funct3, idu_idu_ir_imm_vld, idu_idu_ir_imm,
    input  idu_idu_ir_type, idu_idu_ir_pipe, idu_idu_ir_ras,
    input  rtu_idu_is_iid_vld, rtu_idu_is_iid, rtu_idu_is_preg_vld, rtu_idu_is_preg,
    output idu_ir_stall,
    output idu_rtu_rob_create_vld, idu_rtu_rob_create_pc,
    output idu_rtu_rob_create_src1, idu_rtu_rob_create_src1_vld, idu_rtu_rob_create_psrc1,
    output idu_rtu_rob_create_src2, idu_rtu_rob_create_src2_vld, idu_rtu_rob_create_psrc2,
    output idu_rtu_rob_create_dst, idu_rtu_rob_create_dst_vld, idu_rtu_rob_create_pdst,
    output idu_rtu_rob_create_iid, idu_rtu_rob_create_opcode, idu_rtu_rob_create_funct3,
    output idu_rtu_rob_create_imm_vld, idu_rtu_rob_create_imm, idu_rtu_rob_create_type,
    output idu_rtu_rob_create_pipe, idu_rtu_rob_create_ras,
    output idu_rtu_pst_create_vld, idu_rtu_pst_create_preg_index, idu_rtu_pst_create_iid,
    output idu_rtu_pst_create_gpr_index, idu_rtu_pst_create_gpr_pre_preg_index
  );

  modport master (
    output rtu_global_flush, rtu_idu_ir_recover_table, y_idu_ir_stall_ctrl,
    output idu_idu_ir_vld, idu_idu_ir_pc,
    output idu_idu_ir_src1_vld, idu_idu_ir_src1, idu_idu_ir_src2_vld, idu_idu_ir_src2,
    output idu_idu_ir_dst_vld, idu_idu_ir_dst,
    output idu_idu_ir_opcode, idu_idu_ir_funct3, idu_idu_ir_imm_vld, idu_idu_ir_imm,
    output idu_idu_ir_type, idu_idu_ir_pipe, idu_idu_ir_ras,
    output rtu_idu_is_iid_vld, rtu_idu_is_iid, rtu_idu_is_preg_vld, rtu_idu_is_preg,
    input  idu_ir_stall,
    input  idu_rtu_rob_create_vld, idu_rtu_rob_create_pc,
    input  idu_rtu_rob_create_src1, idu_rtu_rob_create_src1_vld, idu_rtu_rob_create_psrc1,
    input  idu_rtu_rob_create_src2, idu_rtu_rob_create_src2_vld, idu_rtu_rob_create_psrc2,
    input  idu_rtu_rob_create_dst, idu_rtu_rob_create_dst_vld, idu_rtu_rob_create_pdst,
    input  idu_rtu_rob_create_iid, idu_rtu_rob_create_opcode, idu_rtu_rob_create_funct3,
    input  idu_rtu_rob_create_imm_vld, idu_rtu_rob_create_imm, idu_rtu_rob_create_type,
    input  idu_rtu_rob_create_pipe, idu_rtu_rob_create_ras,
    input  idu_rtu_pst_create_vld, idu_rtu_pst_create_preg_index, idu_rtu_pst_create_iid,
    input  idu_rtu_pst_create_gpr_index, idu_rtu_pst_create_gpr_pre_preg_index
  );

endinterface

// File: rtl/idu_ir_rename_rt.sv
// Speculative rename table: 32 x PREG_W flops, three combinational read
// ports, one write port and a bulk load from the committed recover map.
module idu_ir_rt
  import idu_ir_rename_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [RT_W-1:0] i_recover,
  input  logic            i_wr_en,
  input  gpr_t            i_wr_idx,
  input  preg_t           i_wr_preg,
  input  gpr_t            i_rd1_idx,
  input  gpr_t            i_rd2_idx,
  input  gpr_t            i_rd3_idx,
  output preg_t           o_rd1_preg,
  output preg_t           o_rd2_preg,
  output preg_t           o_rd3_preg
);

  preg_t w_rt [GPR_NUM];

  // x0 has no storage: it always maps to preg 0, whatever the recover bus says.
  assign w_rt[0] = '0;

  for (genvar gi = 1; gi < GPR_NUM; gi++) begin : g_entry
    preg_t r_map;

    // NOTE: the table is built from flops with a reset value (identity map),
    // not from a RAM macro, because every entry must be valid straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_map <= preg_t'(gi);
      end else if (i_load) begin
        r_map <= i_recover[gi*PREG_W +: PREG_W];
      end else if (i_wr_en && (i_wr_idx == gpr_t'(gi))) begin
        r_map <= i_wr_preg;
      end
    end

    assign w_rt[gi] = r_map;
  end

  // Reads see the table before this cycle's write lands.
  assign o_rd1_preg = w_rt[i_rd1_idx];
  assign o_rd2_preg = w_rt[i_rd2_idx];
  assign o_rd3_preg = w_rt[i_rd3_idx];

endmodule

// File: rtl/idu_ir_rename.sv
// Single-issue rename stage: stall/accept logic, rename-table update and
// the one-deep output register feeding the ROB and PST create ports.
module idu_ir_rename
  import idu_ir_rename_pkg::*;
(
  input  logic            clk,
  input  logic            rst_clk,
  idu_ir_rename_if.slave  bus
);

  ir_out_t r_out;
  logic    r_rob_vld;
  logic    r_pst_vld;

  logic    w_flush;
  logic    w_need_preg;
  logic    w_hold;
  logic    w_lack;
  logic    w_stall;
  logic    w_accept;
  preg_t   w_rt_src1;
  preg_t   w_rt_src2;
  preg_t   w_rt_dst;

  assign w_flush     = bus.rtu_global_flush;
  assign w_need_preg = need_preg(bus.idu_idu_ir_dst_vld, bus.idu_idu_ir_dst);
  assign w_hold      = r_rob_vld && bus.y_idu_ir_stall_ctrl;
  assign w_lack      = !bus.rtu_idu_is_iid_vld || (w_need_preg && !bus.rtu_idu_is_preg_vld);
  assign w_stall     = bus.idu_idu_ir_vld && (w_hold || w_lack) && !w_flush;
  assign w_accept    = bus.idu_idu_ir_vld && !w_stall && !w_flush;

  idu_ir_rt u_rt (
    .clk        (clk),
    .rst_n      (rst_clk),
    .i_load     (w_flush),
    .i_recover  (bus.rtu_idu_ir_recover_table),
    .i_wr_en    (w_accept && w_need_preg),
    .i_wr_idx   (bus.idu_idu_ir_dst),
    .i_wr_preg  (bus.rtu_idu_is_preg),
    .i_rd1_idx  (bus.idu_idu_ir_src1),
    .i_rd2_idx  (bus.idu_idu_ir_src2),
    .i_rd3_idx  (bus.idu_idu_ir_dst),
    .o_rd1_preg (w_rt_src1),
    .o_rd2_preg (w_rt_src2),
    .o_rd3_preg (w_rt_dst)
  );

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      r_out     <= '0;
      r_rob_vld <= 1'b0;
      r_pst_vld <= 1'b0;
    end else if (w_flush) begin
      r_rob_vld <= 1'b0;
      r_pst_vld <= 1'b0;
    end else if (w_accept) begin
      r_rob_vld      <= 1'b1;
      r_pst_vld      <= w_need_preg;
      r_out.pc       <= bus.idu_idu_ir_pc;
      r_out.src1_vld <= bus.idu_idu_ir_src1_vld;
      r_out.src1     <= bus.idu_idu_ir_src1;
      r_out.psrc1    <= (bus.idu_idu_ir_src1 == '0) ? '0 : w_rt_src1;
      r_out.src2_vld <= bus.idu_idu_ir_src2_vld;
      r_out.src2     <= bus.idu_idu_ir_src2;
      r_out.psrc2    <= (bus.idu_idu_ir_src2 == '0) ? '0 : w_rt_src2;
      r_out.dst_vld  <= w_need_preg;
      r_out.dst      <= bus.idu_idu_ir_dst;
      r_out.pdst     <= bus.rtu_idu_is_preg;
      r_out.pre_preg <= w_rt_dst;
      r_out.iid      <= bus.rtu_idu_is_iid;
      r_out.opcode   <= bus.idu_idu_ir_opcode;
      r_out.funct3   <= bus.idu_idu_ir_funct3;
      r_out.imm_vld  <= bus.idu_idu_ir_imm_vld;
      r_out.imm      <= bus.idu_idu_ir_imm;
      r_out.itype    <= bus.idu_idu_ir_type;
      r_out.pipe     <= bus.idu_idu_ir_pipe;
      r_out.ras      <= bus.idu_idu_ir_ras;
    end else if (!w_hold) begin
      r_rob_vld <= 1'b0;
      r_pst_vld <= 1'b0;
    end
  end

  assign bus.idu_ir_stall = w_stall;

  assign bus.idu_rtu_rob_create_vld      = r_rob_vld;
  assign bus.idu_rtu_rob_create_pc       = r_out.pc;
  assign bus.idu_rtu_rob_create_src1     = r_out.src1;
  assign bus.idu_rtu_rob_create_src1_vld = r_out.src1_vld;
  assign bus.idu_rtu_rob_create_psrc1    = r_out.psrc1;
  assign bus.idu_rtu_rob_create_src2     = r_out.src2;
  assign bus.idu_rtu_rob_create_src2_vld = r_out.src2_vld;
  assign bus.idu_rtu_rob_create_psrc2    = r_out.psrc2;
  assign bus.idu_rtu_rob_create_dst      = r_out.dst;
  assign bus.idu_rtu_rob_create_dst_vld  = r_out.dst_vld;
  assign bus.idu_rtu_rob_create_pdst     = r_out.pdst;
  assign bus.idu_rtu_rob_create_iid      = r_out.iid;
  assign bus.idu_rtu_rob_create_opcode   = r_out.opcode;
  assign bus.idu_rtu_rob_create_funct3   = r_out.funct3;
  assign bus.idu_rtu_rob_create_imm_vld  = r_out.imm_vld;
  assign bus.idu_rtu_rob_create_imm      = r_out.imm;
  assign bus.idu_rtu_rob_create_type     = r_out.itype;
  assign bus.idu_rtu_rob_create_pipe     = r_out.pipe;
  assign bus.idu_rtu_rob_create_ras      = r_out.ras;

  assign bus.idu_rtu_pst_create_vld                = r_pst_vld;
  assign bus.idu_rtu_pst_create_preg_index         = r_out.pdst;
  assign bus.idu_rtu_pst_create_iid                = r_out.iid;
  assign bus.idu_rtu_pst_create_gpr_index          = r_out.dst;
  assign bus.idu_rtu_pst_create_gpr_pre_preg_index = r_out.pre_preg;

endmodule

// File: tb/tb_idu_ir_rename.sv
// Directed bench for idu_ir_rename: renaming, RAW chains, stalls, hold,
// flush recovery and asynchronous reset, with hand-computed expectations.
module tb_idu_ir_rename;
  import idu_ir_rename_pkg::*;

  logic clk;
  logic rst_clk;
  int   n_assert;
  int   n_fail;
  logic [RT_W-1:0] rec;

  idu_ir_rename_if bus ();

  idu_ir_rename dut (
    .clk     (clk),
    .rst_clk (rst_clk),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic s1v, input gpr_t s1, input logic s2v, input gpr_t s2,
                        input logic dv, input gpr_t d);
    bus.idu_idu_ir_vld      = 1'b1;
    bus.idu_idu_ir_src1_vld = s1v;
    bus.idu_idu_ir_src1     = s1;
    bus.idu_idu_ir_src2_vld = s2v;
    bus.idu_idu_ir_src2     = s2;
    bus.idu_idu_ir_dst_vld  = dv;
    bus.idu_idu_ir_dst      = d;
  endtask

  task automatic set_res(input logic iv, input iid_t iid, input logic pv, input preg_t preg);
    bus.rtu_idu_is_iid_vld  = iv;
    bus.rtu_idu_is_iid      = iid;
    bus.rtu_idu_is_preg_vld = pv;
    bus.rtu_idu_is_preg     = preg;
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_clk  = 1'b0;
    bus.rtu_global_flush         = 1'b0;
    bus.rtu_idu_ir_recover_table = '0;
    bus.y_idu_ir_stall_ctrl      = 1'b0;
    bus.idu_idu_ir_vld           = 1'b0;
    bus.idu_idu_ir_pc            = '0;
    bus.idu_idu_ir_src1_vld      = 1'b0;
    bus.idu_idu_ir_src1          = '0;
    bus.idu_idu_ir_src2_vld      = 1'b0;
    bus.idu_idu_ir_src2          = '0;
    bus.idu_idu_ir_dst_vld       = 1'b0;
    bus.idu_idu_ir_dst           = '0;
    bus.idu_idu_ir_opcode        = 7'h33;
    bus.idu_idu_ir_funct3        = 3'd0;
    bus.idu_idu_ir_imm_vld       = 1'b0;
    bus.idu_idu_ir_imm           = '0;
    bus.idu_idu_ir_type          = 6'd1;
    bus.idu_idu_ir_pipe          = 5'd2;
    bus.idu_idu_ir_ras           = 1'b0;
    bus.rtu_idu_is_iid_vld       = 1'b0;
    bus.rtu_idu_is_iid           = '0;
    bus.rtu_idu_is_preg_vld      = 1'b0;
    bus.rtu_idu_is_preg          = '0;

    // Reset state
    #2;
    check("rst_rob_vld", bus.idu_rtu_rob_create_vld, 0);
    check("rst_pst_vld", bus.idu_rtu_pst_create_vld, 0);
    check("rst_pdst",    bus.idu_rtu_rob_create_pdst, 0);
    check("rst_stall",   bus.idu_ir_stall, 0);
    @(negedge clk);
    rst_clk = 1'b1;

    // 1: add x5,x1,x2 iid=3 preg=40
    bus.idu_idu_ir_pc = 64'h8000_1000;
    set_ir(1, 5'd1, 1, 5'd2, 1, 5'd5);
    set_res(1, 4'd3, 1, 6'd40);
    check("t1_stall", bus.idu_ir_stall, 0);
    step();
    check("t1_rob_vld", bus.idu_rtu_rob_create_vld, 1);
    check("t1_pc",      bus.idu_rtu_rob_create_pc, 64'h8000_1000);
    check("t1_psrc1",   bus.idu_rtu_rob_create_psrc1, 1);
    check("t1_psrc2",   bus.idu_rtu_rob_create_psrc2, 2);
    check("t1_pdst",    bus.idu_rtu_rob_create_pdst, 40);
    check("t1_pst_vld", bus.idu_rtu_pst_create_vld, 1);
    check("t1_gpr",     bus.idu_rtu_pst_create_gpr_index, 5);
    check("t1_pre",     bus.idu_rtu_pst_create_gpr_pre_preg_index, 5);
    check("t1_iid",     bus.idu_rtu_pst_create_iid, 3);

    // 2: x6 = x5 + x5, preg 41
    set_ir(1, 5'd5, 1, 5'd5, 1, 5'd6);
    set_res(1, 4'd4, 1, 6'd41);
    step();
    check("t2_psrc1", bus.idu_rtu_rob_create_psrc1, 40);
    check("t2_psrc2", bus.idu_rtu_rob_create_psrc2, 40);
    check("t2_pdst",  bus.idu_rtu_pst_create_preg_index, 41);
    check("t2_pre",   bus.idu_rtu_pst_create_gpr_pre_preg_index, 6);

    // src == dst: x5 = x5 + x1 sees the old mapping of x5
    set_ir(1, 5'd5, 1, 5'd1, 1, 5'd5);
    set_res(1, 4'd5, 1, 6'd42);
    step();
    check("sd_psrc1", bus.idu_rtu_rob_create_psrc1, 40);
    check("sd_pre",   bus.idu_rtu_pst_create_gpr_pre_preg_index, 40);
    check("sd_pdst",  bus.idu_rtu_rob_create_pdst, 42);

    // 3: dst x0 with no preg offered
    set_ir(1, 5'd6, 1, 5'd5, 1, 5'd0);
    set_res(1, 4'd6, 0, 6'd0);
    check("t3_stall", bus.idu_ir_stall, 0);
    step();
    check("t3_rob_vld", bus.idu_rtu_rob_create_vld, 1);
    check("t3_pst_vld", bus.idu_rtu_pst_create_vld, 0);
    check("t3_dst_vld", bus.idu_rtu_rob_create_dst_vld, 0);
    check("t3_psrc1",   bus.idu_rtu_rob_create_psrc1, 41);
    check("t3_psrc2",   bus.idu_rtu_rob_create_psrc2, 42);

    // 4: x7 = x5 waits three cycles for a preg
    set_ir(1, 5'd5, 0, 5'd0, 1, 5'd7);
    set_res(1, 4'd7, 0, 6'd0);
    for (int c = 0; c < 3; c++) begin
      check("t4_stall", bus.idu_ir_stall, 1);
      step();
      check("t4_rob_vld", bus.idu_rtu_rob_create_vld, 0);
      check("t4_pst_vld", bus.idu_rtu_pst_create_vld, 0);
    end
    set_res(1, 4'd7, 1, 6'd43);
    check("t4_go_stall", bus.idu_ir_stall, 0);
    step();
    check("t4_rob_vld1", bus.idu_rtu_rob_create_vld, 1);
    check("t4_psrc1",    bus.idu_rtu_rob_create_psrc1, 42);
    check("t4_pdst",     bus.idu_rtu_rob_create_pdst, 43);
    check("t4_pre",      bus.idu_rtu_pst_create_gpr_pre_preg_index, 7);

    // 5: downstream back-pressure holds outputs for two cycles
    bus.y_idu_ir_stall_ctrl = 1'b1;
    set_ir(1, 5'd7, 0, 5'd0, 1, 5'd8);
    set_res(1, 4'd8, 1, 6'd44);
    for (int c = 0; c < 2; c++) begin
      check("t5_stall", bus.idu_ir_stall, 1);
      step();
      check("t5_rob_vld", bus.idu_rtu_rob_create_vld, 1);
      check("t5_pdst",    bus.idu_rtu_rob_create_pdst, 43);
      check("t5_iid",     bus.idu_rtu_rob_create_iid, 7);
    end
    bus.y_idu_ir_stall_ctrl = 1'b0;
    #1;
    check("t5_release", bus.idu_ir_stall, 0);
    step();
    check("t5_psrc1", bus.idu_rtu_rob_create_psrc1, 43);
    check("t5_pdst",  bus.idu_rtu_rob_create_pdst, 44);

    // 6: rename x5->45, then flush with a new instruction pending
    set_ir(0, 5'd0, 0, 5'd0, 1, 5'd5);
    set_res(1, 4'd9, 1, 6'd45);
    step();
    check("t6_pre", bus.idu_rtu_pst_create_gpr_pre_preg_index, 42);
    for (int i = 0; i < GPR_NUM; i++) rec[i*PREG_W +: PREG_W] = preg_t'(i);
    rec[9*PREG_W +: PREG_W] = 6'd50;
    rec[0 +: PREG_W]        = 6'd63;
    bus.rtu_idu_ir_recover_table = rec;
    bus.rtu_global_flush = 1'b1;
    set_ir(1, 5'd5, 0, 5'd0, 1, 5'd10);
    set_res(1, 4'd10, 1, 6'd46);
    check("t6_flush_stall", bus.idu_ir_stall, 0);
    step();
    check("t6_rob_vld", bus.idu_rtu_rob_create_vld, 0);
    check("t6_pst_vld", bus.idu_rtu_pst_create_vld, 0);
    bus.rtu_global_flush = 1'b0;
    set_ir(1, 5'd5, 1, 5'd9, 1, 5'd7);
    set_res(1, 4'd10, 1, 6'd46);
    step();
    check("t6_psrc1", bus.idu_rtu_rob_create_psrc1, 5);
    check("t6_psrc2", bus.idu_rtu_rob_create_psrc2, 50);
    check("t6_pre",   bus.idu_rtu_pst_create_gpr_pre_preg_index, 7);
    check("t6_iid",   bus.idu_rtu_rob_create_iid, 10);

    // Flush beats an active hold
    bus.y_idu_ir_stall_ctrl = 1'b1;
    bus.rtu_global_flush    = 1'b1;
    set_res(1, 4'd11, 1, 6'd47);
    check("fh_stall", bus.idu_ir_stall, 0);
    step();
    check("fh_rob_vld", bus.idu_rtu_rob_create_vld, 0);
    bus.y_idu_ir_stall_ctrl = 1'b0;
    bus.rtu_global_flush    = 1'b0;

    // Missing iid stalls even without a destination
    set_ir(1, 5'd1, 0, 5'd0, 0, 5'd0);
    set_res(0, 4'd0, 1, 6'd47);
    check("iid_stall", bus.idu_ir_stall, 1);
    step();
    check("iid_rob_vld", bus.idu_rtu_rob_create_vld, 0);

    // Asynchronous reset mid-operation
    set_ir(1, 5'd2, 0, 5'd0, 1, 5'd5);
    set_res(1, 4'd12, 1, 6'd48);
    step();
    check("ar_pre_vld", bus.idu_rtu_rob_create_vld, 1);
    #2;
    rst_clk = 1'b0;
    #1;
    check("ar_rob_vld", bus.idu_rtu_rob_create_vld, 0);
    check("ar_pst_vld", bus.idu_rtu_pst_create_vld, 0);
    check("ar_pdst",    bus.idu_rtu_rob_create_pdst, 0);
    @(negedge clk);
    rst_clk = 1'b1;
    set_ir(1, 5'd5, 1, 5'd9, 1, 5'd11);
    set_res(1, 4'd13, 1, 6'd49);
    step();
    check("ar_psrc1", bus.idu_rtu_rob_create_psrc1, 5);
    check("ar_psrc2", bus.idu_rtu_rob_create_psrc2, 9);

    // Idle clears valids
    bus.idu_idu_ir_vld = 1'b0;
    step();
    check("idle_rob_vld", bus.idu_rtu_rob_create_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
